// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the 5-stage MIPS pipe.
// Define IF_PERF_CNT_EN to build the fetch/bubble/stall performance counters.
module if_fetch_stage #(
    parameter logic [31:0] TEXT_BASE = 32'h0000_3000,
    parameter int unsigned IM_AW     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       ID_NPCOp,
    input  logic             ID_branchTaken,
    input  logic [31:0]      ID_jrTarget,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    output logic [31:0]      IF_PC,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_inst,
    output logic             ID_valid,
    output logic [31:0]      fetch_cnt,
    output logic [31:0]      bubble_cnt,
    output logic [31:0]      stall_cnt
);

    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;

    logic [31:0] pc_off;
    logic [31:0] id_pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;
    logic [31:0] redirect_target;
    logic        take;
    logic        redirect;
    logic        do_fetch;
    logic        do_bubble;
    logic        do_stall;

    always_comb begin
        pc_off      = if_pc_q - TEXT_BASE;
        id_pc_plus4 = id_pc_q + 32'd4;
        br_target   = id_pc_plus4
                    + {{14{id_inst_q[15]}}, id_inst_q[15:0], 2'b00};
        j_target    = {id_pc_plus4[31:28], id_inst_q[25:0], 2'b00};
        jr_target   = {ID_jrTarget[31:2], 2'b00};

        take            = 1'b0;
        redirect_target = br_target;
        case (ID_NPCOp)
            2'b01: take = ID_branchTaken;
            2'b10: begin
                take            = 1'b1;
                redirect_target = j_target;
            end
            2'b11: begin
                take            = 1'b1;
                redirect_target = jr_target;
            end
            default: take = 1'b0;
        endcase

        // A bubble in ID carries no control transfer, whatever NPCOp says.
        redirect  = id_valid_q & ~stall & take;
        do_stall  = ~rst & stall;
        do_bubble = ~rst & redirect;
        do_fetch  = ~rst & ~stall & ~redirect;

        if_pc_d    = if_pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        if (redirect) begin
            if_pc_d    = redirect_target;
            id_pc_d    = if_pc_q;
            id_inst_d  = 32'h0;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            if_pc_d    = if_pc_q + 32'd4;
            id_pc_d    = if_pc_q;
            id_inst_d  = im_rdata;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc_q    <= TEXT_BASE;
            id_pc_q    <= 32'h0;
            id_inst_q  <= 32'h0;
            id_valid_q <= 1'b0;
        end else begin
            if_pc_q    <= if_pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign im_addr  = pc_off[IM_AW+1:2];
    assign IF_PC    = if_pc_q;
    assign ID_PC    = id_pc_q;
    assign ID_inst  = id_inst_q;
    assign ID_valid = id_valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + {31'h0, do_fetch};
        bubble_cnt_d = bubble_cnt_q + {31'h0, do_bubble};
        stall_cnt_d  = stall_cnt_q + {31'h0, do_stall};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
            stall_cnt_q  <= 32'h0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;

    logic unused_bits;
    assign unused_bits = ^{pc_off[31:IM_AW+2], pc_off[1:0],
                           ID_jrTarget[1:0], id_inst_q[31:26]};
`else
    assign fetch_cnt  = 32'h0;
    assign bubble_cnt = 32'h0;
    assign stall_cnt  = 32'h0;

    logic unused_bits;
    assign unused_bits = ^{pc_off[31:IM_AW+2], pc_off[1:0],
                           ID_jrTarget[1:0], id_inst_q[31:26],
                           do_fetch, do_bubble, do_stall};
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed test-plan scenarios
// followed by randomized traffic against a behavioural reference model.
module tb_if_fetch_stage;

`ifdef IF_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  npc_op;
    logic        br_taken;
    logic [31:0] jr_tgt;
    logic [9:0]  im_addr;
    logic [31:0] im_rdata;
    logic [31:0] if_pc, id_pc, id_inst;
    logic        id_valid;
    logic [31:0] fetch_cnt, bubble_cnt, stall_cnt;

    logic [31:0] imem [1024];
    assign im_rdata = imem[im_addr];

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .ID_NPCOp(npc_op), .ID_branchTaken(br_taken),
        .ID_jrTarget(jr_tgt), .im_addr(im_addr), .im_rdata(im_rdata),
        .IF_PC(if_pc), .ID_PC(id_pc), .ID_inst(id_inst),
        .ID_valid(id_valid), .fetch_cnt(fetch_cnt),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc, m_idpc, m_inst;
    logic        m_valid;
    logic [31:0] m_fc, m_bc, m_sc;

    function automatic logic [31:0] m_word(input logic [31:0] pc);
        return imem[((pc - 32'h3000) >> 2) % 1024];
    endfunction

    // Drive one cycle of inputs, clock it, advance the model.
    task automatic step(input logic r, input logic s, input logic [1:0] op,
                        input logic bt, input logic [31:0] jr);
        logic [31:0] tgt;
        logic        go;
        rst = r; stall = s; npc_op = op; br_taken = bt; jr_tgt = jr;
        @(posedge clk);
        go = m_valid && (op == 2'd2 || op == 2'd3 || (op == 2'd1 && bt));
        case (op)
            2'd1: tgt = m_idpc + 32'd4 + 32'(int'($signed(m_inst[15:0])) * 4);
            2'd2: tgt = ((m_idpc + 32'd4) & 32'hF000_0000)
                      | ((m_inst & 32'h03FF_FFFF) * 4);
            default: tgt = jr & ~32'd3;
        endcase
        if (r) begin
            m_pc = 32'h3000; m_idpc = 0; m_inst = 0; m_valid = 0;
            m_fc = 0; m_bc = 0; m_sc = 0;
        end else if (s) begin
            m_sc++;
        end else if (go) begin
            m_idpc = m_pc; m_inst = 0; m_valid = 0; m_pc = tgt; m_bc++;
        end else begin
            m_inst = m_word(m_pc); m_idpc = m_pc; m_valid = 1;
            m_pc = m_pc + 32'd4; m_fc++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 2'd0, 0, 0);
        step(1, 0, 2'd0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (if_pc !== 32'h3000) begin errors++;
            $display("FAIL rst_if_pc: got %h exp 00003000", if_pc); end
        checks++; if (im_addr !== 10'd0) begin errors++;
            $display("FAIL rst_im_addr: got %h exp 000", im_addr); end
        checks++; if (id_valid !== 1'b0 || id_inst !== 0 || id_pc !== 0) begin
            errors++;
            $display("FAIL rst_slot: got v=%b inst=%h pc=%h exp 0/0/0",
                     id_valid, id_inst, id_pc); end
        checks++; if ({fetch_cnt, bubble_cnt, stall_cnt} !== 96'h0) begin
            errors++;
            $display("FAIL rst_cnt: got %h %h %h exp 0",
                     fetch_cnt, bubble_cnt, stall_cnt); end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc = '{32'h3004, 32'h3008, 32'h300C};
        exp_in = '{32'h20010005, 32'h20020007, 32'h00221820};
        for (int i = 0; i < 1024; i++) imem[i] = 0;
        imem[0] = 32'h20010005; imem[1] = 32'h20020007; imem[2] = 32'h00221820;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checks++;
            if (if_pc !== exp_pc[i] || id_inst !== exp_in[i] ||
                id_valid !== 1'b1 || id_pc !== exp_pc[i] - 32'd4) begin
                errors++;
                $display("FAIL free_run[%0d]: got pc=%h inst=%h v=%b idpc=%h exp %h %h 1 %h",
                         i, if_pc, id_inst, id_valid, id_pc,
                         exp_pc[i], exp_in[i], exp_pc[i] - 32'd4);
            end
        end
        checks++; if (fetch_cnt !== (PERF ? 32'd3 : 32'd0)) begin errors++;
            $display("FAIL free_fetch_cnt: got %0d exp %0d",
                     fetch_cnt, PERF ? 3 : 0); end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 1024; i++) imem[i] = 0;
        imem[2] = 32'h1000FFFE;
        do_reset();
        idle(3);
        step(0, 0, 2'd1, 1, 0);
        checks++; if (if_pc !== 32'h3004 || id_valid !== 1'b0) begin errors++;
            $display("FAIL br_redirect: got pc=%h v=%b exp 00003004 0",
                     if_pc, id_valid); end
        checks++; if (bubble_cnt !== (PERF ? 32'd1 : 32'd0)) begin errors++;
            $display("FAIL br_bubble_cnt: got %0d exp %0d",
                     bubble_cnt, PERF ? 1 : 0); end
        step(0, 0, 2'd1, 0, 0);
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3004 ||
                      if_pc !== 32'h3008) begin errors++;
            $display("FAIL br_target_id: got v=%b idpc=%h pc=%h exp 1 00003004 00003008",
                     id_valid, id_pc, if_pc); end
    endtask

    task automatic test_jump();
        for (int i = 0; i < 1024; i++) imem[i] = 0;
        imem[4] = 32'h08000C00;
        do_reset();
        idle(5);
        step(0, 0, 2'd2, 0, 0);
        checks++; if (if_pc !== 32'h3000 || id_valid !== 1'b0) begin errors++;
            $display("FAIL j_redirect: got pc=%h v=%b exp 00003000 0",
                     if_pc, id_valid); end
        step(0, 0, 2'd2, 0, 0);
        checks++; if (if_pc !== 32'h3004 || id_valid !== 1'b1) begin errors++;
            $display("FAIL bubble_no_redirect: got pc=%h v=%b exp 00003004 1",
                     if_pc, id_valid); end
    endtask

    task automatic test_jr();
        do_reset();
        idle(1);
        step(0, 0, 2'd3, 0, 32'h0000_300E);
        checks++; if (if_pc !== 32'h300C || im_addr !== 10'd3) begin errors++;
            $display("FAIL jr_target: got pc=%h ia=%h exp 0000300c 003",
                     if_pc, im_addr); end
    endtask

    task automatic test_stall_redirect();
        for (int i = 0; i < 1024; i++) imem[i] = 0;
        imem[2] = 32'h1000FFFE;
        do_reset();
        idle(3);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 2'd1, 1, 0);
            checks++;
            if (if_pc !== 32'h300C || id_pc !== 32'h3008 ||
                id_inst !== 32'h1000FFFE || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got pc=%h idpc=%h inst=%h v=%b exp 0000300c 00003008 1000fffe 1",
                         i, if_pc, id_pc, id_inst, id_valid);
            end
        end
        checks++; if (stall_cnt !== (PERF ? 32'd2 : 32'd0)) begin errors++;
            $display("FAIL stall_cnt: got %0d exp %0d",
                     stall_cnt, PERF ? 2 : 0); end
        step(0, 0, 2'd1, 1, 0);
        checks++; if (if_pc !== 32'h3004 || id_valid !== 1'b0) begin errors++;
            $display("FAIL stall_then_redirect: got pc=%h v=%b exp 00003004 0",
                     if_pc, id_valid); end
    endtask

    task automatic test_reset_during_stall();
        do_reset();
        idle(3);
        step(0, 1, 2'd1, 1, 0);
        step(1, 1, 2'd1, 1, 0);
        checks++; if (if_pc !== 32'h3000 || id_valid !== 1'b0 ||
                      {fetch_cnt, bubble_cnt, stall_cnt} !== 96'h0) begin
            errors++;
            $display("FAIL rst_in_stall: got pc=%h v=%b cnt=%h/%h/%h exp 00003000 0 0",
                     if_pc, id_valid, fetch_cnt, bubble_cnt, stall_cnt); end
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [31:0] exp_ia;
        for (int i = 0; i < 1024; i++) imem[i] = $urandom;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) op = 2'd0;
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                 op, 1'($urandom), $urandom);
            exp_ia = ((m_pc - 32'h3000) >> 2) % 1024;
            checks++;
            if (if_pc !== m_pc || id_pc !== m_idpc || id_inst !== m_inst ||
                id_valid !== m_valid || im_addr !== exp_ia[9:0]) begin
                errors++;
                $display("FAIL rand_state[%0d]: got %h %h %h %b %h exp %h %h %h %b %h",
                         n, if_pc, id_pc, id_inst, id_valid, im_addr,
                         m_pc, m_idpc, m_inst, m_valid, exp_ia[9:0]);
            end
            checks++;
            if (fetch_cnt !== (PERF ? m_fc : 0) ||
                bubble_cnt !== (PERF ? m_bc : 0) ||
                stall_cnt !== (PERF ? m_sc : 0)) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d %0d %0d exp %0d %0d %0d",
                         n, fetch_cnt, bubble_cnt, stall_cnt,
                         PERF ? m_fc : 0, PERF ? m_bc : 0, PERF ? m_sc : 0);
            end
        end
    endtask

    initial begin
        rst = 1; stall = 0; npc_op = 0; br_taken = 0; jr_tgt = 0;
        m_pc = 32'h3000; m_idpc = 0; m_inst = 0; m_valid = 0;
        m_fc = 0; m_bc = 0; m_sc = 0;
        for (int i = 0; i < 1024; i++) imem[i] = 0;
        test_reset();
        test_free_run();
        test_branch();
        test_jump();
        test_jr();
        test_stall_redirect();
        test_reset_during_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
